// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the bimodal branch predictor.
// The table storage and indexing live in branch_predictor; this holds only the common encodings.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  // Tag storage is sized for the smallest BTB; narrower real tags are zero-extended.
  localparam int BP_TAG_W = 30;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
  } bp_btb_entry_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;
  localparam int      BP_PC_ALIGN  = 2;

  function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [31:0] pc, input int idx_bits);
    return BP_TAG_W'(pc >> (idx_bits + BP_PC_ALIGN));
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Combinational next-state function of a 2-bit saturating branch counter.
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      case (ctr)
        SNT:     ctr_next = WNT;
        WNT:     ctr_next = WT;
        default: ctr_next = ST;
      endcase
    end else begin
      case (ctr)
        ST:      ctr_next = WT;
        WT:      ctr_next = WNT;
        default: ctr_next = SNT;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal BHT + direct-mapped BTB: predicts at IF, resolves/trains at EX.
// Define GSHARE_EN to XOR a resolve-time global history register into the BHT index.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_IDX_BITS = 6,
  parameter int BTB_IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        ex_mispredict,
  output logic [31:0] ex_redirect_pc
`ifdef GSHARE_EN
  ,
  output logic [BHT_IDX_BITS-1:0] pred_ghr,
  input  logic [BHT_IDX_BITS-1:0] ex_ghr
`endif
);

  localparam int BHT_N = 1 << BHT_IDX_BITS;
  localparam int BTB_N = 1 << BTB_IDX_BITS;

  bp_ctr_t       bht_q [BHT_N];
  bp_ctr_t       bht_d [BHT_N];
  bp_btb_entry_t btb_q [BTB_N];
  bp_btb_entry_t btb_d [BTB_N];

  logic [BHT_IDX_BITS-1:0] if_bht_idx, ex_bht_idx;
  logic [BTB_IDX_BITS-1:0] if_btb_idx, ex_btb_idx;
  bp_ctr_t                 if_ctr, ex_ctr, ex_ctr_next;
  bp_btb_entry_t           if_entry;
  logic                    btb_hit;

`ifdef GSHARE_EN
  logic [BHT_IDX_BITS-1:0] ghr_q, ghr_d;

  assign if_bht_idx = if_pc[BHT_IDX_BITS+1:BP_PC_ALIGN] ^ ghr_q;
  assign ex_bht_idx = ex_pc[BHT_IDX_BITS+1:BP_PC_ALIGN] ^ ex_ghr;
  assign pred_ghr   = ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (ex_valid) ghr_d = {ghr_q[BHT_IDX_BITS-2:0], ex_taken};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  assign if_bht_idx = if_pc[BHT_IDX_BITS+1:BP_PC_ALIGN];
  assign ex_bht_idx = ex_pc[BHT_IDX_BITS+1:BP_PC_ALIGN];
`endif

  assign if_btb_idx = if_pc[BTB_IDX_BITS+1:BP_PC_ALIGN];
  assign ex_btb_idx = ex_pc[BTB_IDX_BITS+1:BP_PC_ALIGN];

  // Prediction reads registered state only, so a same-cycle update is seen next cycle.
  assign if_ctr   = bht_q[if_bht_idx];
  assign if_entry = btb_q[if_btb_idx];
  assign btb_hit  = if_entry.valid && (if_entry.tag == bp_tag(if_pc, BTB_IDX_BITS));

  assign pred_taken  = btb_hit && if_ctr[1];
  assign pred_target = btb_hit ? if_entry.target : 32'd0;

  assign ex_ctr = bht_q[ex_bht_idx];

  sat_ctr2 u_sat_ctr2 (
    .ctr      (ex_ctr),
    .taken    (ex_taken),
    .ctr_next (ex_ctr_next)
  );

  always_comb begin
    bht_d = bht_q;
    btb_d = btb_q;
    if (ex_valid) begin
      bht_d[ex_bht_idx] = ex_ctr_next;
      if (ex_taken) begin
        btb_d[ex_btb_idx] = '{valid: 1'b1, tag: bp_tag(ex_pc, BTB_IDX_BITS), target: ex_target};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= BP_CTR_RESET;
      for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
    end else begin
      bht_q <= bht_d;
      btb_q <= btb_d;
    end
  end

  // Resolve outputs are forced quiet during reset even if EX inputs are still driven.
  always_comb begin
    ex_mispredict  = 1'b0;
    ex_redirect_pc = 32'd0;
    if (ex_valid && !rst) begin
      ex_mispredict  = (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
      ex_redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (bimodal build; GSHARE_EN adds a history test).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
`ifdef GSHARE_EN
  logic [5:0]  pred_ghr;
  logic [5:0]  ex_ghr = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .ex_mispredict  (ex_mispredict),
    .ex_redirect_pc (ex_redirect_pc)
`ifdef GSHARE_EN
    ,
    .pred_ghr       (pred_ghr),
    .ex_ghr         (ex_ghr)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic t,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_pc          = pc;
    ex_taken       = t;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic do_reset();
    drive_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    if_pc = 32'h40;
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken got %b want 0", pred_taken); end
    n_checks++;
    if (pred_target !== 32'd0) begin n_fail++; $display("FAIL reset_pred_target got %h want 0", pred_target); end
    n_checks++;
    if (ex_mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict got %b want 0", ex_mispredict); end
    n_checks++;
    if (ex_redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_redirect got %h want 0", ex_redirect_pc); end
    do_reset();
  endtask

  task automatic test_train_saturate();
    logic exp_pt;
    do_reset();
    if_pc = 32'h40;
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL first_pred_taken got %b want 0", pred_taken); end
    n_checks++;
    if (ex_mispredict !== 1'b1) begin n_fail++; $display("FAIL first_mispredict got %b want 1", ex_mispredict); end
    n_checks++;
    if (ex_redirect_pc !== 32'h80) begin n_fail++; $display("FAIL first_redirect got %h want 00000080", ex_redirect_pc); end
    step();
    ex_valid = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL wt_pred_taken got %b want 1", pred_taken); end
    n_checks++;
    if (pred_target !== 32'h80) begin n_fail++; $display("FAIL wt_pred_target got %h want 00000080", pred_target); end
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    #1;
    n_checks++;
    if (ex_mispredict !== 1'b0) begin n_fail++; $display("FAIL correct_pred_mispredict got %b want 0", ex_mispredict); end
    step();
    // From ST: WT, WNT, SNT, SNT, SNT.
    for (int i = 0; i < 5; i++) begin
      drive_ex(1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
      #1;
      n_checks++;
      if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'h44) begin
        n_fail++;
        $display("FAIL nt_resolve_%0d got mp=%b pc=%h want mp=1 pc=00000044", i, ex_mispredict, ex_redirect_pc);
      end
      step();
      ex_valid = 1'b0;
      #1;
      exp_pt = (i == 0);
      n_checks++;
      if (pred_taken !== exp_pt) begin n_fail++; $display("FAIL decrement_%0d pred_taken got %b want %b", i, pred_taken, exp_pt); end
    end
    // One taken from saturated SNT lands on WNT: still not taken, target still hits.
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    ex_valid = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL snt_saturate pred_taken got %b want 0", pred_taken); end
    n_checks++;
    if (pred_target !== 32'h80) begin n_fail++; $display("FAIL wnt_hit_target got %h want 00000080", pred_target); end
  endtask

  task automatic test_btb_alias();
    do_reset();
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    drive_ex(1'b1, 32'h440, 1'b1, 32'h900, 1'b0, 32'h0);
    step();
    ex_valid = 1'b0;
    if_pc    = 32'h40;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_tag_miss pred_taken got %b want 0", pred_taken); end
    n_checks++;
    if (pred_target !== 32'd0) begin n_fail++; $display("FAIL alias_tag_miss target got %h want 0", pred_target); end
    if_pc = 32'h440;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h900) begin
      n_fail++;
      $display("FAIL alias_new_entry got pt=%b tgt=%h want pt=1 tgt=00000900", pred_taken, pred_target);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    drive_ex(1'b1, 32'h40, 1'b1, 32'h84, 1'b1, 32'h80);
    #1;
    n_checks++;
    if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'h84) begin
      n_fail++;
      $display("FAIL wrong_target got mp=%b pc=%h want mp=1 pc=00000084", ex_mispredict, ex_redirect_pc);
    end
    drive_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h100, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (ex_mispredict !== 1'b0 || ex_redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_redirect got mp=%b pc=%h want mp=0 pc=00000000", ex_mispredict, ex_redirect_pc);
    end
    drive_ex(1'b1, 32'h1000, 1'b0, 32'h2000, 1'b1, 32'h2000);
    #1;
    n_checks++;
    if (ex_mispredict !== 1'b1 || ex_redirect_pc !== 32'h1004) begin
      n_fail++;
      $display("FAIL predicted_taken_was_nt got mp=%b pc=%h want mp=1 pc=00001004", ex_mispredict, ex_redirect_pc);
    end
    drive_ex(1'b1, 32'h1000, 1'b0, 32'h2000, 1'b0, 32'h5555);
    #1;
    n_checks++;
    if (ex_mispredict !== 1'b0) begin n_fail++; $display("FAIL nt_ignores_target got %b want 0", ex_mispredict); end
    drive_ex(1'b0, 32'h1000, 1'b1, 32'h2000, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (ex_mispredict !== 1'b0) begin n_fail++; $display("FAIL invalid_gates_mispredict got %b want 0", ex_mispredict); end
    step();
  endtask

  task automatic test_collision();
    do_reset();
    if_pc = 32'h40;
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL collision_same_cycle got %b want 0", pred_taken); end
    step();
    drive_ex(1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL collision_next_cycle got %b want 1", pred_taken); end
    step();
    ex_valid = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL collision_dec_visible got %b want 0", pred_taken); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_pc = 32'h40;
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'd0 || ex_mispredict !== 1'b0 || ex_redirect_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got pt=%b tgt=%h mp=%b pc=%h want all 0",
               pred_taken, pred_target, ex_mispredict, ex_redirect_pc);
    end
    step();
    rst      = 1'b0;
    ex_valid = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_btb got pt=%b tgt=%h want pt=0 tgt=0", pred_taken, pred_target);
    end
    drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    drive_ex(1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    ex_valid = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL post_reset_ctr_wnt got %b want 0", pred_taken); end
  endtask

`ifdef GSHARE_EN
  task automatic test_gshare();
    do_reset();
    ex_ghr = '0;
    if_pc  = 32'h40;
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      step();
    end
    ex_valid = 1'b0;
    #1;
    n_checks++;
    if (pred_ghr !== 6'b000111) begin n_fail++; $display("FAIL gshare_ghr got %b want 000111", pred_ghr); end
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL gshare_other_history got %b want 0", pred_taken); end
  endtask
`endif

  initial begin
    test_reset();
    test_mispredict();
`ifndef GSHARE_EN
    test_train_saturate();
    test_btb_alias();
    test_collision();
    test_reset_mid();
`else
    test_gshare();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
